// File: rtl/alu_exec.sv
// alu_exec: single-lane RV32I ALU execution stage watching one reservation-station slot.
// Optional multi-cycle multiply is built only when ALU_EXEC_MUL_EN is defined.
module alu_exec #(
    parameter int TAG_W        = 5,
    parameter int OP_W         = 5,
    parameter int UNLOCKED_TAG = 0,
    parameter int MUL_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             flush,
    input  logic             rs_busy,
    input  logic [OP_W-1:0]  rs_op,
    input  logic [31:0]      rs_pc,
    input  logic [TAG_W-1:0] rs_tagx,
    input  logic [TAG_W-1:0] rs_tagy,
    input  logic [31:0]      rs_datax,
    input  logic [31:0]      rs_datay,
    input  logic [TAG_W-1:0] rs_tagw,
    input  logic [4:0]       rs_target,
    output logic             busy_alu,
    output logic [31:0]      alu_data,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic [4:0]       res_target,
    input  logic             cdb_grant
);

    localparam logic [TAG_W-1:0] L_UNLOCKED = TAG_W'(UNLOCKED_TAG);
    localparam logic [OP_W-1:0]  OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0]  OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0]  OP_SLL   = OP_W'(2);
    localparam logic [OP_W-1:0]  OP_SLT   = OP_W'(3);
    localparam logic [OP_W-1:0]  OP_SLTU  = OP_W'(4);
    localparam logic [OP_W-1:0]  OP_XOR   = OP_W'(5);
    localparam logic [OP_W-1:0]  OP_SRL   = OP_W'(6);
    localparam logic [OP_W-1:0]  OP_SRA   = OP_W'(7);
    localparam logic [OP_W-1:0]  OP_OR    = OP_W'(8);
    localparam logic [OP_W-1:0]  OP_AND   = OP_W'(9);
    localparam logic [OP_W-1:0]  OP_LUI   = OP_W'(10);
    localparam logic [OP_W-1:0]  OP_AUIPC = OP_W'(11);
    localparam logic [OP_W-1:0]  OP_LINK  = OP_W'(12);
`ifdef ALU_EXEC_MUL_EN
    localparam logic [OP_W-1:0]  OP_MUL   = OP_W'(13);
    localparam int               CNT_W    = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ALU_EXEC_MUL_EN
        S_EXEC = 2'd2,
`endif
        S_WB   = 2'd1
    } state_t;

    state_t      r_state;
    logic        w_tags_ready;
    logic        w_slot_free;
    logic        w_cap;
    logic [31:0] w_result;
`ifdef ALU_EXEC_MUL_EN
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_mul_x;
    logic [31:0]      r_mul_y;
    logic             r_mul_zero;
    logic             w_is_mul;
`endif

    // Single-cycle integer result; reserved codes yield zero.
    function automatic logic [31:0] f_alu(input logic [OP_W-1:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] pc);
        logic [31:0] r;
        case (op)
            OP_ADD:   r = x + y;
            OP_SUB:   r = x - y;
            OP_SLL:   r = x << y[4:0];
            OP_SLT:   r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_SLTU:  r = (x < y) ? 32'd1 : 32'd0;
            OP_XOR:   r = x ^ y;
            OP_SRL:   r = x >> y[4:0];
            OP_SRA:   r = $signed(x) >>> y[4:0];
            OP_OR:    r = x | y;
            OP_AND:   r = x & y;
            OP_LUI:   r = y;
            OP_AUIPC: r = pc + y;
            OP_LINK:  r = pc + 32'd4;
            default:  r = 32'd0;
        endcase
        return r;
    endfunction

    // Capture decision and the consume handshake back to the RS slot.
    always_comb begin
        w_tags_ready = (rs_tagx == L_UNLOCKED) && (rs_tagy == L_UNLOCKED);
        w_slot_free  = (r_state == S_IDLE) || ((r_state == S_WB) && cdb_grant);
        w_cap        = rst_n && rdy && !flush && rs_busy && w_tags_ready && w_slot_free;
        busy_alu     = !w_cap;
        if (rs_target == 5'd0) begin
            w_result = 32'd0;
        end else begin
            w_result = f_alu(rs_op, rs_datax, rs_datay, rs_pc);
        end
`ifdef ALU_EXEC_MUL_EN
        w_is_mul = (rs_op == OP_MUL);
`endif
    end

    // Execution FSM with registered result bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            alu_data   <= 32'd0;
            res_valid  <= 1'b0;
            res_tag    <= L_UNLOCKED;
            res_target <= 5'd0;
`ifdef ALU_EXEC_MUL_EN
            r_cnt      <= '0;
            r_mul_x    <= 32'd0;
            r_mul_y    <= 32'd0;
            r_mul_zero <= 1'b0;
`endif
        end else if (rdy) begin
            if (flush) begin
                r_state   <= S_IDLE;
                res_valid <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
                r_cnt     <= '0;
`endif
            end else if (w_cap) begin
                res_tag    <= rs_tagw;
                res_target <= rs_target;
`ifdef ALU_EXEC_MUL_EN
                if (w_is_mul) begin
                    r_state    <= S_EXEC;
                    r_cnt      <= CNT_LOAD;
                    r_mul_x    <= rs_datax;
                    r_mul_y    <= rs_datay;
                    r_mul_zero <= (rs_target == 5'd0);
                    res_valid  <= 1'b0;
                end else begin
                    r_state   <= S_WB;
                    alu_data  <= w_result;
                    res_valid <= 1'b1;
                end
`else
                r_state   <= S_WB;
                alu_data  <= w_result;
                res_valid <= 1'b1;
`endif
            end else begin
                case (r_state)
                    S_WB: begin
                        if (cdb_grant) begin
                            r_state   <= S_IDLE;
                            res_valid <= 1'b0;
                        end else begin
                            r_state <= S_WB;
                        end
                    end
`ifdef ALU_EXEC_MUL_EN
                    // Counter reaching its last step lands the product on the bus.
                    S_EXEC: begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt     <= '0;
                            r_state   <= S_WB;
                            alu_data  <= r_mul_zero ? 32'd0 : (r_mul_x * r_mul_y);
                            res_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_LAST;
                        end
                    end
`endif
                    default: r_state <= S_IDLE;
                endcase
            end
        end else begin
            r_state <= r_state;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Randomized self-checking bench for alu_exec against an abstract result-slot model.
module tb_alu_exec;
    localparam int TAG_W      = 5;
    localparam int OP_W       = 5;
    localparam int MUL_CYCLES = 4;
`ifdef ALU_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk, rst_n, rdy, flush, rs_busy, cdb_grant;
    logic [OP_W-1:0]  rs_op;
    logic [31:0]      rs_pc, rs_datax, rs_datay;
    logic [TAG_W-1:0] rs_tagx, rs_tagy, rs_tagw;
    logic [4:0]       rs_target;
    logic             busy_alu, res_valid;
    logic [31:0]      alu_data;
    logic [TAG_W-1:0] res_tag;
    logic [4:0]       res_target;

    int n_checks = 0;
    int n_errors = 0;

    // Model: one visible result slot plus an optional pending product.
    bit          m_valid;
    logic [31:0] m_data, m_pdata;
    logic [4:0]  m_tag, m_target, m_ptag, m_ptarget;
    int          m_pend;

    alu_exec #(.TAG_W(TAG_W), .OP_W(OP_W), .UNLOCKED_TAG(0), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush), .rs_busy(rs_busy),
        .rs_op(rs_op), .rs_pc(rs_pc), .rs_tagx(rs_tagx), .rs_tagy(rs_tagy),
        .rs_datax(rs_datax), .rs_datay(rs_datay), .rs_tagw(rs_tagw), .rs_target(rs_target),
        .busy_alu(busy_alu), .alu_data(alu_data), .res_valid(res_valid), .res_tag(res_tag),
        .res_target(res_target), .cdb_grant(cdb_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model_fn(int op, logic [31:0] x, logic [31:0] y,
                                             logic [31:0] pc, logic [4:0] tgt);
        logic [31:0] r;
        int sh;
        sh = int'(y[4:0]);
        case (op)
            0:  r = x + y;
            1:  r = x - y;
            2:  r = x << sh;
            3:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4:  r = (x < y) ? 32'd1 : 32'd0;
            5:  r = x ^ y;
            6:  r = x >> sh;
            7:  r = $signed(x) >>> sh;
            8:  r = x | y;
            9:  r = x & y;
            10: r = y;
            11: r = pc + y;
            12: r = pc + 32'd4;
            default: r = 32'd0;
        endcase
        if (tgt == 5'd0) r = 32'd0;
        return r;
    endfunction

    function automatic bit model_cap();
        bit idle;
        idle = !m_valid && (m_pend == 0);
        return rdy && !flush && rs_busy && (rs_tagx == 5'd0) && (rs_tagy == 5'd0) &&
               (idle || (m_valid && cdb_grant));
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_pend  = 0;
    endtask

    task automatic model_update(input bit cap);
        if (rdy) begin
            if (flush) begin
                model_reset();
            end else if (cap) begin
                if (MUL_EN && int'(rs_op) == 13) begin
                    m_valid   = 1'b0;
                    m_pend    = MUL_CYCLES - 1;
                    m_pdata   = (rs_target == 5'd0) ? 32'd0 : rs_datax * rs_datay;
                    m_ptag    = rs_tagw;
                    m_ptarget = rs_target;
                end else begin
                    m_valid  = 1'b1;
                    m_data   = model_fn(int'(rs_op), rs_datax, rs_datay, rs_pc, rs_target);
                    m_tag    = rs_tagw;
                    m_target = rs_target;
                end
            end else if (m_pend > 0) begin
                m_pend = m_pend - 1;
                if (m_pend == 0) begin
                    m_valid  = 1'b1;
                    m_data   = m_pdata;
                    m_tag    = m_ptag;
                    m_target = m_ptarget;
                end
            end else if (m_valid && cdb_grant) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare against the model, then advance one clock; returns at the next falling edge.
    task automatic step();
        bit cap;
        #1;
        cap = model_cap();
        chk("busy_alu", {31'd0, busy_alu}, {31'd0, !cap});
        chk("res_valid", {31'd0, res_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("alu_data", alu_data, m_data);
            chk("res_tag", {27'd0, res_tag}, {27'd0, m_tag});
            chk("res_target", {27'd0, res_target}, {27'd0, m_target});
        end
        @(posedge clk);
        model_update(cap);
        @(negedge clk);
    endtask

    task automatic entry(input int op, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] tx, input logic [4:0] ty, input logic [4:0] tw,
                         input logic [4:0] tgt);
        rs_busy = 1'b1; rs_op = OP_W'(op); rs_datax = x; rs_datay = y;
        rs_tagx = tx; rs_tagy = ty; rs_tagw = tw; rs_target = tgt;
    endtask

    task automatic drain();
        rs_busy = 1'b0; cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;
    endtask

    task automatic run_one(input string name, input int op, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] pc, input logic [4:0] tgt,
                           input logic [31:0] exp);
        entry(op, x, y, 5'd0, 5'd0, 5'd11, tgt);
        rs_pc = pc;
        #1 chk({name, "_busy"}, {31'd0, busy_alu}, 32'd0);
        step();
        rs_busy = 1'b0;
        #1 chk({name, "_valid"}, {31'd0, res_valid}, 32'd1);
        chk({name, "_data"}, alu_data, exp);
        drain();
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; cdb_grant = 1'b0; rs_pc = 32'd0;
        entry(0, 32'd5, 32'd7, 5'd0, 5'd0, 5'd3, 5'd9);
        model_reset();
        @(negedge clk); #1;
        chk("rst_busy", {31'd0, busy_alu}, 32'd1);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_data", alu_data, 32'd0);
        chk("rst_tag", {27'd0, res_tag}, 32'd0);
        chk("rst_target", {27'd0, res_target}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        entry(0, 32'd5, 32'd7, 5'd0, 5'd0, 5'd3, 5'd9);
        #1 chk("add_busy", {31'd0, busy_alu}, 32'd0);
        step();
        rs_busy = 1'b0;
        #1 chk("add_valid", {31'd0, res_valid}, 32'd1);
        chk("add_data", alu_data, 32'd12);
        chk("add_tag", {27'd0, res_tag}, 32'd3);
        chk("add_target", {27'd0, res_target}, 32'd9);
        drain();

        entry(5, 32'hF0F0_0000, 32'h0F0F_00FF, 5'd4, 5'd0, 5'd6, 5'd2);
        for (int i = 0; i < 3; i++) begin
            #1 chk("locked_busy", {31'd0, busy_alu}, 32'd1);
            step();
        end
        rs_tagx = 5'd0;
        #1 chk("unlock_busy", {31'd0, busy_alu}, 32'd0);
        step();
        rs_busy = 1'b0;
        #1 chk("unlock_valid", {31'd0, res_valid}, 32'd1);
        chk("unlock_data", alu_data, 32'hFFFF_00FF);

        entry(7, 32'h8000_0000, 32'd4, 5'd0, 5'd0, 5'd7, 5'd4);
        for (int i = 0; i < 5; i++) begin
            #1 chk("hold_busy", {31'd0, busy_alu}, 32'd1);
            chk("hold_data", alu_data, 32'hFFFF_00FF);
            step();
        end
        cdb_grant = 1'b1;
        #1 chk("b2b_busy", {31'd0, busy_alu}, 32'd0);
        step();
        cdb_grant = 1'b0; rs_busy = 1'b0;
        #1 chk("b2b_valid", {31'd0, res_valid}, 32'd1);
        chk("b2b_data", alu_data, 32'hF800_0000);
        chk("b2b_tag", {27'd0, res_tag}, 32'd7);
        drain();

        run_one("sub",   1,  32'd0,         32'd1,         32'd0,      5'd1, 32'hFFFF_FFFF);
        run_one("slt",   3,  32'hFFFF_FFFF, 32'd1,         32'd0,      5'd1, 32'd1);
        run_one("sltu",  4,  32'hFFFF_FFFF, 32'd1,         32'd0,      5'd1, 32'd0);
        run_one("sll",   2,  32'd1,         32'd33,        32'd0,      5'd1, 32'd2);
        run_one("srl",   6,  32'h8000_0000, 32'd31,        32'd0,      5'd1, 32'd1);
        run_one("addwr", 0,  32'hFFFF_FFFF, 32'd2,         32'd0,      5'd1, 32'd1);
        run_one("lui",   10, 32'd9,         32'h1234_5000, 32'd0,      5'd1, 32'h1234_5000);
        run_one("auipc", 11, 32'd0,         32'h10,        32'h1000,   5'd1, 32'h1010);
        run_one("link",  12, 32'd0,         32'd0,         32'h1000,   5'd1, 32'h1004);
        run_one("x0",    0,  32'd5,         32'd7,         32'd0,      5'd0, 32'd0);
        run_one("resv",  14, 32'd5,         32'd7,         32'd0,      5'd1, 32'd0);

        entry(0, 32'd1, 32'd2, 5'd0, 5'd0, 5'd5, 5'd1);
        step();
        flush = 1'b1; cdb_grant = 1'b1;
        #1 chk("flush_busy", {31'd0, busy_alu}, 32'd1);
        step();
        flush = 1'b0; cdb_grant = 1'b0; rs_busy = 1'b0;
        #1 chk("flush_valid", {31'd0, res_valid}, 32'd0);
        step();

        entry(13, 32'd3, 32'd5, 5'd0, 5'd0, 5'd2, 5'd1);
        step();
        step();
        #2 rst_n = 1'b0;
        #1 chk("areset_valid", {31'd0, res_valid}, 32'd0);
        chk("areset_busy", {31'd0, busy_alu}, 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; rs_busy = 1'b0;
        step();
        #1 chk("areset_nostale", {31'd0, res_valid}, 32'd0);

`ifdef ALU_EXEC_MUL_EN
        entry(13, 32'h0001_0000, 32'h0001_0001, 5'd0, 5'd0, 5'd8, 5'd3);
        #1 chk("mul_busy", {31'd0, busy_alu}, 32'd0);
        step();
        rs_busy = 1'b0;
        for (int k = 2; k <= MUL_CYCLES; k++) begin
            #1 chk("mul_wait", {31'd0, res_valid}, 32'd0);
            step();
        end
        #1 chk("mul_valid", {31'd0, res_valid}, 32'd1);
        chk("mul_data", alu_data, 32'h0001_0000);
        drain();
        entry(13, 32'h0001_0000, 32'h0001_0001, 5'd0, 5'd0, 5'd8, 5'd3);
        step();
        rs_busy = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            rdy = (k == 3 || k == 4) ? 1'b0 : 1'b1;
            #1 chk("mul_stall_wait", {31'd0, res_valid}, 32'd0);
            step();
        end
        rdy = 1'b1;
        #1 chk("mul_stall_valid", {31'd0, res_valid}, 32'd1);
        chk("mul_stall_data", alu_data, 32'h0001_0000);
        drain();
`endif

        for (int n = 0; n < 3000; n++) begin
            rdy       = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cdb_grant = ($urandom_range(0, 1) == 1);
            rs_busy   = ($urandom_range(0, 9) < 7);
            rs_op     = ($urandom_range(0, 7) == 0) ? OP_W'($urandom_range(0, 31))
                                                    : OP_W'($urandom_range(0, 15));
            rs_tagx   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            rs_tagy   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            rs_tagw   = 5'($urandom_range(0, 31));
            rs_target = ($urandom_range(0, 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rs_datax  = $urandom;
            rs_datay  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rs_pc     = $urandom & 32'hFFFF_FFFC;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
